// File: rtl/uart_rx_deframer_pkg.sv
// Shared types, default line constants and parity helper for the UART receive path.
package uart_rx_deframer_pkg;

  localparam int unsigned CLKRATE_DEF     = 614400;
  localparam int unsigned BAUD_DEF        = 9600;
  localparam int unsigned WORD_LENGTH_DEF = 8;
  localparam int unsigned OVERSAMPLE_DEF  = 16;
  localparam int unsigned PAR_MAX_W       = 32;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BRK_WAIT
  } rx_state_t;

  // XOR reduction; a word plus its even-parity bit reduces to 0.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_rx_deframer_baud_tick.sv
// Free-running oversample tick: one-clk pulse every CLKRATE/(BAUD*OVERSAMPLE) clocks.
module uart_rx_deframer_baud_tick #(
  parameter int unsigned CLKRATE    = 614400,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned DIV = CLKRATE / (BAUD * OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          tick_q, tick_d;

  // Divider wrap; tick_q is high exactly while div_cnt_q sits at DIV-1.
  always_comb begin
    div_cnt_d = div_cnt_q + CW'(1);
    if (div_cnt_q == CW'(DIV - 1)) div_cnt_d = '0;
    tick_d = (div_cnt_d == CW'(DIV - 1));
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receiver: synchronise, mid-bit sample, deframe and hold the word until acked.
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int unsigned CLKRATE     = CLKRATE_DEF,
  parameter int unsigned BAUD        = BAUD_DEF,
  parameter int unsigned WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int unsigned PARITY_EN   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   UART_Rx_IN,
  input  logic                   Rx_ACK,
  output logic [WORD_LENGTH-1:0] Rx_DATA,
  output logic                   Rx_VALID,
  output logic                   Rx_PARITY_ERR,
  output logic                   Rx_FRAME_ERR,
  output logic                   Rx_OVERRUN,
  output logic                   UART_Rx_BUSY
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(WORD_LENGTH + 1);

  logic                   tick;
  logic [1:0]             sync_q;
  logic                   line;
  rx_state_t              state_q, state_d;
  logic [SW-1:0]          s_cnt_q, s_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   deliver_q, deliver_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_o_q, perr_o_d;
  logic                   ferr_o_q, ferr_o_d;
  logic                   ovr_q, ovr_d;
  logic                   busy_q, busy_d;

  uart_rx_deframer_baud_tick #(
    .CLKRATE   (CLKRATE),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign line = sync_q[1];

  // Frame FSM (tick-paced) plus the valid/ack holding register.
  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    deliver_d = 1'b0;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_o_d  = perr_o_q;
    ferr_o_d  = ferr_o_q;
    ovr_d     = ovr_q;

    if (tick) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!line) begin
            state_d = RX_START;
            s_cnt_d = '0;
            perr_d  = 1'b0;
          end
        end
        RX_START: begin
          if (s_cnt_q == SW'(OVERSAMPLE / 2 - 1)) begin
            s_cnt_d   = '0;
            bit_cnt_d = '0;
            state_d   = line ? RX_IDLE : RX_DATA;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
        RX_DATA: begin
          if (s_cnt_q == SW'(OVERSAMPLE - 1)) begin
            shift_d   = {line, shift_q[WORD_LENGTH-1:1]};
            s_cnt_d   = '0;
            bit_cnt_d = bit_cnt_q + BW'(1);
            if (bit_cnt_q == BW'(WORD_LENGTH - 1)) begin
              state_d = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
        RX_PARITY: begin
          if (s_cnt_q == SW'(OVERSAMPLE - 1)) begin
            perr_d  = even_parity(PAR_MAX_W'(shift_q)) ^ line;
            s_cnt_d = '0;
            state_d = RX_STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
        RX_STOP: begin
          if (s_cnt_q == SW'(OVERSAMPLE - 1)) begin
            ferr_d    = ~line;
            deliver_d = 1'b1;
            s_cnt_d   = '0;
            state_d   = line ? RX_IDLE : RX_BRK_WAIT;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
        RX_BRK_WAIT: begin
          // Held-low line must return high before a new start is accepted.
          if (line) state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end

    if (deliver_q) begin
      if (!valid_q || Rx_ACK) begin
        data_d   = shift_q;
        perr_o_d = perr_q;
        ferr_o_d = ferr_q;
        valid_d  = 1'b1;
        if (Rx_ACK) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (Rx_ACK && valid_q) begin
      valid_d  = 1'b0;
      ovr_d    = 1'b0;
      perr_o_d = 1'b0;
      ferr_o_d = 1'b0;
    end

    busy_d = (state_d != RX_IDLE);
  end

  // State and output registers; synchroniser resets to idle-high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= 2'b11;
      state_q   <= RX_IDLE;
      s_cnt_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      deliver_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_o_q  <= 1'b0;
      ferr_o_q  <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], UART_Rx_IN};
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      deliver_q <= deliver_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_o_q  <= perr_o_d;
      ferr_o_q  <= ferr_o_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
    end
  end

  assign Rx_DATA       = data_q;
  assign Rx_VALID      = valid_q;
  assign Rx_PARITY_ERR = perr_o_q;
  assign Rx_FRAME_ERR  = ferr_o_q;
  assign Rx_OVERRUN    = ovr_q;
  assign UART_Rx_BUSY  = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench: table of frames on the plain receiver, hand sequences for corner cases.
module tb_uart_rx_deframer;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       line0 = 1'b1, line1 = 1'b1;
  logic       ack0 = 1'b0, ack1 = 1'b0;
  logic [7:0] data0, data1;
  logic       valid0, valid1, perr0, perr1, ferr0, ferr1, ovr0, ovr1, busy0, busy1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_deframer #(
    .CLKRATE(614400), .BAUD(9600), .WORD_LENGTH(8), .OVERSAMPLE(16), .PARITY_EN(0)
  ) dut (
    .clk(clk), .rst(rst), .UART_Rx_IN(line0), .Rx_ACK(ack0),
    .Rx_DATA(data0), .Rx_VALID(valid0), .Rx_PARITY_ERR(perr0),
    .Rx_FRAME_ERR(ferr0), .Rx_OVERRUN(ovr0), .UART_Rx_BUSY(busy0)
  );

  uart_rx_deframer #(
    .CLKRATE(614400), .BAUD(9600), .WORD_LENGTH(8), .OVERSAMPLE(16), .PARITY_EN(1)
  ) dut_p (
    .clk(clk), .rst(rst), .UART_Rx_IN(line1), .Rx_ACK(ack1),
    .Rx_DATA(data1), .Rx_VALID(valid1), .Rx_PARITY_ERR(perr1),
    .Rx_FRAME_ERR(ferr1), .Rx_OVERRUN(ovr1), .UART_Rx_BUSY(busy1)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_line(input bit which, input logic v);
    if (which) line1 = v;
    else       line0 = v;
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input bit use_par,
                            input logic par, input logic stop, input int stop_len,
                            input bit release_line);
    set_line(which, 1'b0);
    hold(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      set_line(which, d[i]);
      hold(BIT_CLK);
    end
    if (use_par) begin
      set_line(which, par);
      hold(BIT_CLK);
    end
    set_line(which, stop);
    hold(stop_len);
    if (release_line) set_line(which, 1'b1);
  endtask

  task automatic wait_valid(input bit which, input int budget, output int took);
    took = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if ((which ? valid1 : valid0) === 1'b1) begin
        took = c + 1;
        break;
      end
    end
  endtask

  task automatic do_ack(input bit which);
    @(negedge clk);
    if (which) ack1 = 1'b1;
    else       ack0 = 1'b1;
    @(negedge clk);
    ack0 = 1'b0;
    ack1 = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  took;
    bit  busy_seen;
    bit  ok;

    vecs[0] = '{8'hA5, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 1'b0};
    vecs[4] = '{8'hC3, 1'b0, 1'b1};

    // Reset state
    repeat (5) @(negedge clk);
    chk("rst_valid", 32'(valid0), 0);
    chk("rst_data", 32'(data0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_ovr", 32'(ovr0), 0);
    chk("rst_ferr", 32'(ferr0), 0);
    chk("rst_perr", 32'(perr0), 0);
    @(negedge clk);
    rst = 1'b1;
    hold(20);

    // Table of single frames, each acked
    for (int v = 0; v < 5; v++) begin
      fork
        send_frame(1'b0, vecs[v].data, 1'b0, 1'b0, vecs[v].stop, BIT_CLK, 1'b1);
        wait_valid(1'b0, 620, took);
      join
      chk("tbl_latency_ok", 32'(took > 0), 1);
      chk("tbl_valid", 32'(valid0), 1);
      chk("tbl_data", 32'(data0), 32'(vecs[v].data));
      chk("tbl_ferr", 32'(ferr0), 32'(vecs[v].exp_ferr));
      chk("tbl_perr", 32'(perr0), 0);
      chk("tbl_ovr", 32'(ovr0), 0);
      hold(8);
      @(negedge clk);
      chk("tbl_idle", 32'(busy0), 0);
      do_ack(1'b0);
      chk("tbl_ack_valid", 32'(valid0), 0);
      chk("tbl_ack_ferr", 32'(ferr0), 0);
      hold(16);
    end

    // Short low glitch: busy pulse, nothing delivered
    busy_seen = 1'b0;
    line0 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      busy_seen |= busy0;
    end
    line0 = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      busy_seen |= busy0;
    end
    chk("glitch_busy_seen", 32'(busy_seen), 1);
    chk("glitch_busy_end", 32'(busy0), 0);
    chk("glitch_valid", 32'(valid0), 0);

    // Stop bit 0 then line held low: one frame only, busy until release
    fork
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 200, 1'b0);
      wait_valid(1'b0, 620, took);
    join
    @(negedge clk);
    chk("brk_latency_ok", 32'(took > 0), 1);
    chk("brk_valid", 32'(valid0), 1);
    chk("brk_data", 32'(data0), 32'h3C);
    chk("brk_ferr", 32'(ferr0), 1);
    chk("brk_busy_low", 32'(busy0), 1);
    line0 = 1'b1;
    hold(20);
    @(negedge clk);
    chk("brk_busy_released", 32'(busy0), 0);
    hold(700);
    @(negedge clk);
    chk("brk_no_second_ovr", 32'(ovr0), 0);
    chk("brk_data_kept", 32'(data0), 32'h3C);
    do_ack(1'b0);
    chk("brk_ack_valid", 32'(valid0), 0);
    chk("brk_ack_ferr", 32'(ferr0), 0);
    hold(16);

    // Overrun: second frame dropped while first is held
    fork
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, BIT_CLK, 1'b1);
      wait_valid(1'b0, 620, took);
    join
    chk("ovr_first_data", 32'(data0), 32'h11);
    hold(16);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, BIT_CLK, 1'b1);
    hold(10);
    @(negedge clk);
    chk("ovr_valid", 32'(valid0), 1);
    chk("ovr_data_kept", 32'(data0), 32'h11);
    chk("ovr_flag", 32'(ovr0), 1);
    do_ack(1'b0);
    chk("ovr_ack_valid", 32'(valid0), 0);
    chk("ovr_ack_flag", 32'(ovr0), 0);
    hold(16);

    // Ack in the same clock as a new load keeps VALID with the new word
    fork
      send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1, BIT_CLK, 1'b1);
      wait_valid(1'b0, 620, took);
    join
    chk("same_first_data", 32'(data0), 32'h33);
    hold(16);
    fork
      send_frame(1'b0, 8'h44, 1'b0, 1'b0, 1'b1, BIT_CLK, 1'b1);
      begin
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (busy0) begin ok = 1'b1; break; end
        end
        if (ok) begin
          ok = 1'b0;
          for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (!busy0) begin ok = 1'b1; break; end
          end
        end
        chk("same_busy_track", 32'(ok), 1);
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
        chk("same_valid", 32'(valid0), 1);
        chk("same_data", 32'(data0), 32'h44);
        chk("same_ovr", 32'(ovr0), 0);
      end
    join
    do_ack(1'b0);
    chk("same_ack_valid", 32'(valid0), 0);
    hold(16);

    // Even parity on the parity-enabled instance, data 0x07 (three ones)
    fork
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, BIT_CLK, 1'b1);
      wait_valid(1'b1, 700, took);
    join
    chk("par_good_latency_ok", 32'(took > 0), 1);
    chk("par_good_data", 32'(data1), 32'h07);
    chk("par_good_perr", 32'(perr1), 0);
    chk("par_good_ferr", 32'(ferr1), 0);
    do_ack(1'b1);
    chk("par_good_ack", 32'(valid1), 0);
    hold(16);
    fork
      send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, BIT_CLK, 1'b1);
      wait_valid(1'b1, 700, took);
    join
    chk("par_bad_latency_ok", 32'(took > 0), 1);
    chk("par_bad_data", 32'(data1), 32'h07);
    chk("par_bad_perr", 32'(perr1), 1);
    do_ack(1'b1);
    chk("par_bad_ack_perr", 32'(perr1), 0);
    hold(16);

    // Async reset during data bit 4 with a word held, then a clean frame
    fork
      send_frame(1'b0, 8'h99, 1'b0, 1'b0, 1'b1, BIT_CLK, 1'b1);
      wait_valid(1'b0, 620, took);
    join
    hold(16);
    line0 = 1'b0;
    hold(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      line0 = i[0];
      hold(BIT_CLK);
    end
    line0 = 1'b1;
    hold(BIT_CLK / 2);
    @(negedge clk);
    chk("rst6_pre_busy", 32'(busy0), 1);
    chk("rst6_pre_valid", 32'(valid0), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst6_valid", 32'(valid0), 0);
    chk("rst6_data", 32'(data0), 0);
    chk("rst6_busy", 32'(busy0), 0);
    hold(4);
    @(negedge clk);
    rst = 1'b1;
    hold(20);
    fork
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, BIT_CLK, 1'b1);
      wait_valid(1'b0, 620, took);
    join
    chk("post_rst_latency_ok", 32'(took > 0), 1);
    chk("post_rst_data", 32'(data0), 32'h5A);
    chk("post_rst_ferr", 32'(ferr0), 0);
    chk("post_rst_ovr", 32'(ovr0), 0);
    do_ack(1'b0);
    chk("post_rst_ack", 32'(valid0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
